sr_lsu: RTL and testbench
=========================

// Module: sr_lsu
// PURPOSE
//  Load/store unit between the decoder's data-memory controls and a req/ack data bus.
//  Per load/store it builds byte enables and lane-replicated write data, runs one bus
//  transaction, and returns aligned, sign/zero-extended read data.
//  Stalls the single-cycle core until the access completes.
// PARAMETERS
//  AW  32  bus/lsuAddr width; busAddr is AW bits with [1:0] forced to 0
// PORTS
//  clk         in   1   core clock; all state on rising edge
//  rst_n       in   1   reset, asynchronous, active-low
//  lsuValid    in   1   current instr is load/store (memToReg | dmWe)
//  dmWe        in   1   1=store, 0=load
//  dmSign      in   1   load sign-extends
//  dmOpByte    in   1   byte access
//  dmOpHalf    in   1   halfword access
//  dmOpWord    in   1   word access
//  lsuAddr     in   AW  effective address (ALU result)
//  lsuWData    in   32  store data (rd2)
//  lsuRData    out  32  formatted load data; valid only in DONE
//  lsuStall    out  1   hold PC/regfile write while 1
//  lsuMisalign out  1   misaligned-access pulse (see CONFIGURATION)
//  busReq      out  1   bus request, held until busAck
//  busWe       out  1   bus write
//  busAddr     out  AW  word-aligned address
//  busBe       out  4   byte enables
//  busWData    out  32  lane-replicated write data
//  busRData    in   32  bus read word, sampled with busAck
//  busAck      in   1   transaction done; ignored unless state==REQ
// BEHAVIOUR
//  - Reset: state=IDLE; busReq, busWe, lsuMisalign=0; busAddr, busBe, busWData, lsuRData=0.
//  - FSM IDLE->REQ (lsuValid); REQ->DONE (busAck); DONE->IDLE always.
//    lsuValid in DONE is ignored: the same instr is still presented and must not restart.
//  - lsuStall = (IDLE & lsuValid) | REQ; combinational; 0 in DONE so the core retires.
//  - Leaving IDLE registers busWe, busAddr, busBe, busWData.
//    All stay stable while busReq=1. busReq = (state==REQ), registered.
//  - Latency: IDLE->DONE = 1 + ack-wait cycles; ack in first REQ cycle => 3 cycles total.
//  - Width: word>half>byte priority if several set; none set = word.
//  - busBe: byte 4'b0001<<a[1:0]; half 4'b0011<<{a[1],1'b0}; word 4'b1111.
//  - busWData: byte {4{wd[7:0]}}; half {2{wd[15:0]}}; word wd.
//  - Read path: lsuRData = extend(busRData >> (8*lane)).
//    Sign extension iff dmSign; lsuRData registered on busAck.
//    For stores, lsuRData=0.
//  - Reset mid-transaction: busReq drops immediately and state returns to IDLE.
//    A late busAck is ignored.
// CONFIGURATION
//  SR_LSU_MISALIGN_EN defined:
//   - Misaligned = half with a[0]=1, or word with a[1:0]!=0.
//   - A misaligned access skips REQ (no busReq) and goes IDLE->DONE.
//   - In DONE: lsuMisalign=1 for one cycle, lsuRData=0, no bus write.
//  SR_LSU_MISALIGN_EN undefined:
//   - Low bits truncated: half uses a[1] lane, word uses lane 0.
//   - lsuMisalign tied 0; no misalign logic synthesised.
// STRUCTURE
//  - sr_cpu.vh: DM_BYTE/DM_HALF/DM_WORD codes, LSU state encodings (IDLE/REQ/DONE),
//    BE base patterns.
//  - Sub-module sr_lsu_align (combinational): BE/wdata generation,
//    read lane shift plus extension.
//  - sr_lsu holds the FSM and registers.
// TESTING
//  1. LB a=0x103, rdata=0x80FF_FF7F, dmSign=1:
//     busBe=4'b1000, busAddr=0x100, lsuRData=0xFFFF_FF80.
//  2. LHU a=0x102, rdata=0x9234_5678: lsuRData=0x0000_9234, busBe=4'b1100.
//  3. SB a=0x201, wd=0xAB: busWe=1, busBe=4'b0010, busWData=0xABAB_ABAB.
//     busReq held 5 cycles until ack; lsuStall=1 throughout, 0 in DONE.
//  4. lsuValid held 4 cycles, ack in first REQ cycle:
//     exactly one busReq episode; lsuStall 1,1,0; then back in IDLE.
//  5. rst_n low while busReq=1, ack arrives after release:
//     busReq=0 immediately, ack ignored, no DONE.
//  6. [SR_LSU_MISALIGN_EN] LW a=0x102:
//     no busReq, lsuMisalign=1 for one cycle, lsuRData=0; macro off: busAddr=0x100, busBe=4'b1111.

Source files
------------

// File: rtl/sr_lsu_pkg.sv
// ---------------------------------------------------------------------------
// sr_lsu_pkg
//  Shared definitions for the load/store unit: FSM state encodings, access
//  size codes, byte-enable base patterns and the access-size decode helper.
//  No ports (package).
// ---------------------------------------------------------------------------
package sr_lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      DM_BYTE = 2'd0,
      DM_HALF = 2'd1,
      DM_WORD = 2'd2
   } dm_size_e;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   // Word beats half beats byte when the decoder sets several flags;
   // no flag at all is treated as a word access.
   function automatic dm_size_e dm_size_sel(input logic op_byte,
                                            input logic op_half,
                                            input logic op_word);
      dm_size_e sz;
      sz = DM_WORD;
      if (op_word)      sz = DM_WORD;
      else if (op_half) sz = DM_HALF;
      else if (op_byte) sz = DM_BYTE;
      return sz;
   endfunction

endpackage

// File: rtl/sr_lsu_align.sv
// ---------------------------------------------------------------------------
// sr_lsu_align
//  Combinational data alignment for the load/store unit.
//  Write side: byte enables and lane-replicated store data from the live
//  access size and low address bits.
//  Read side: shifts the addressed lane of the bus word down to bit 0 and
//  sign/zero-extends it to 32 bits.
//  Ports:
//   wr_size, wr_addr_lo, wr_data -> wr_be, wr_rep     (store formatting)
//   rd_size, rd_addr_lo, rd_sign, rd_word -> rd_data  (load formatting)
//  Lane selection truncates low address bits: a half uses a[1], a word
//  always uses lane 0.
// ---------------------------------------------------------------------------
module sr_lsu_align
   import sr_lsu_pkg::*;
(
   input  dm_size_e    wr_size,
   input  logic [1:0]  wr_addr_lo,
   input  logic [31:0] wr_data,
   output logic [3:0]  wr_be,
   output logic [31:0] wr_rep,
   input  dm_size_e    rd_size,
   input  logic [1:0]  rd_addr_lo,
   input  logic        rd_sign,
   input  logic [31:0] rd_word,
   output logic [31:0] rd_data
);

   logic [1:0]  wr_lane;
   logic [1:0]  rd_lane;
   logic [31:0] rd_shifted;

   always_comb begin
      wr_lane = 2'd0;
      wr_be   = BE_WORD;
      wr_rep  = wr_data;
      case (wr_size)
         DM_BYTE: begin
            wr_lane = wr_addr_lo;
            wr_be   = BE_BYTE << wr_lane;
            wr_rep  = {4{wr_data[7:0]}};
         end
         DM_HALF: begin
            wr_lane = {wr_addr_lo[1], 1'b0};
            wr_be   = BE_HALF << wr_lane;
            wr_rep  = {2{wr_data[15:0]}};
         end
         default: begin
            wr_lane = 2'd0;
            wr_be   = BE_WORD;
            wr_rep  = wr_data;
         end
      endcase
   end

   always_comb begin
      rd_lane = 2'd0;
      case (rd_size)
         DM_BYTE: rd_lane = rd_addr_lo;
         DM_HALF: rd_lane = {rd_addr_lo[1], 1'b0};
         default: rd_lane = 2'd0;
      endcase
      rd_shifted = rd_word >> {rd_lane, 3'b000};
      case (rd_size)
         DM_BYTE: rd_data = {{24{rd_sign & rd_shifted[7]}},  rd_shifted[7:0]};
         DM_HALF: rd_data = {{16{rd_sign & rd_shifted[15]}}, rd_shifted[15:0]};
         default: rd_data = rd_shifted;
      endcase
   end

endmodule

// File: rtl/sr_lsu.sv
// ---------------------------------------------------------------------------
// sr_lsu
//  Load/store unit between the decoder's data-memory controls and a req/ack
//  data bus. One bus transaction per load/store; the core is stalled until
//  the access completes.
//  Ports:
//   clk, rst_n                      clock, async active-low reset
//   lsuValid, dmWe, dmSign,
//   dmOpByte/Half/Word, lsuAddr,
//   lsuWData                        access request from the decoder/ALU
//   lsuRData                        formatted load data (valid in DONE)
//   lsuStall                        hold PC / regfile write
//   lsuMisalign                     misaligned-access pulse
//   busReq/We/Addr/Be/WData         bus request side
//   busRData, busAck                bus response side
//   dbg_state                       current FSM state (lsu_state_e encoding)
//  Build option: SR_LSU_MISALIGN_EN enables misaligned-access detection;
//  without it low address bits are simply truncated.
//
//  Bus handshake: busReq rises the cycle after the access leaves IDLE and
//  stays high, with busWe/busAddr/busBe/busWData frozen, until a cycle in
//  which busAck is sampled high; that cycle also carries busRData. busAck
//  outside REQ has no effect.
// ---------------------------------------------------------------------------
module sr_lsu
   import sr_lsu_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          lsuValid,
   input  logic          dmWe,
   input  logic          dmSign,
   input  logic          dmOpByte,
   input  logic          dmOpHalf,
   input  logic          dmOpWord,
   input  logic [AW-1:0] lsuAddr,
   input  logic [31:0]   lsuWData,
   output logic [31:0]   lsuRData,
   output logic          lsuStall,
   output logic          lsuMisalign,
   output logic          busReq,
   output logic          busWe,
   output logic [AW-1:0] busAddr,
   output logic [3:0]    busBe,
   output logic [31:0]   busWData,
   input  logic [31:0]   busRData,
   input  logic          busAck,
   output logic [1:0]    dbg_state
);

   lsu_state_e    state_q,     state_d;
   logic          bus_req_q,   bus_req_d;
   logic          bus_we_q,    bus_we_d;
   logic [AW-1:0] bus_addr_q,  bus_addr_d;
   logic [3:0]    bus_be_q,    bus_be_d;
   logic [31:0]   bus_wdata_q, bus_wdata_d;
   logic [31:0]   rdata_q,     rdata_d;
   // Access shape captured at launch so the read path does not depend on
   // the core keeping its decode outputs steady.
   dm_size_e      size_q,      size_d;
   logic [1:0]    lane_q,      lane_d;
   logic          sign_q,      sign_d;

   dm_size_e      size_w;
   logic [3:0]    be_w;
   logic [31:0]   wrep_w;
   logic [31:0]   rfmt_w;
   logic          misalign_w;

   assign size_w = dm_size_sel(dmOpByte, dmOpHalf, dmOpWord);

   sr_lsu_align u_align (
      .wr_size    (size_w),
      .wr_addr_lo (lsuAddr[1:0]),
      .wr_data    (lsuWData),
      .wr_be      (be_w),
      .wr_rep     (wrep_w),
      .rd_size    (size_q),
      .rd_addr_lo (lane_q),
      .rd_sign    (sign_q),
      .rd_word    (busRData),
      .rd_data    (rfmt_w)
   );

`ifdef SR_LSU_MISALIGN_EN
   logic misalign_q, misalign_d;

   always_comb begin
      misalign_w = 1'b0;
      if (size_w == DM_HALF) misalign_w = lsuAddr[0];
      else if (size_w == DM_WORD) misalign_w = (lsuAddr[1:0] != 2'b00);
   end

   assign lsuMisalign = misalign_q;
`else
   assign misalign_w  = 1'b0;
   assign lsuMisalign = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      rdata_d     = rdata_q;
      size_d      = size_q;
      lane_d      = lane_q;
      sign_d      = sign_q;
`ifdef SR_LSU_MISALIGN_EN
      misalign_d  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (lsuValid) begin
               bus_we_d    = dmWe;
               bus_addr_d  = {lsuAddr[AW-1:2], 2'b00};
               bus_be_d    = be_w;
               bus_wdata_d = wrep_w;
               size_d      = size_w;
               lane_d      = lsuAddr[1:0];
               sign_d      = dmSign;
               if (misalign_w) begin
                  // Trap path: never touches the bus, so no write may leak.
                  state_d  = ST_DONE;
                  bus_we_d = 1'b0;
                  rdata_d  = '0;
`ifdef SR_LSU_MISALIGN_EN
                  misalign_d = 1'b1;
`endif
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (busAck) begin
               state_d = ST_DONE;
               rdata_d = bus_we_q ? 32'd0 : rfmt_w;
            end
         end
         // The core still presents the same instruction here; lsuValid is
         // deliberately not looked at so the access does not restart.
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      bus_req_d = (state_d == ST_REQ);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= 4'b0000;
         bus_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
         size_q      <= DM_WORD;
         lane_q      <= 2'd0;
         sign_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         rdata_q     <= rdata_d;
         size_q      <= size_d;
         lane_q      <= lane_d;
         sign_q      <= sign_d;
      end
   end

`ifdef SR_LSU_MISALIGN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign_q <= 1'b0;
      else        misalign_q <= misalign_d;
   end
`endif

   assign lsuStall  = ((state_q == ST_IDLE) & lsuValid) | (state_q == ST_REQ);
   assign busReq    = bus_req_q;
   assign busWe     = bus_we_q;
   assign busAddr   = bus_addr_q;
   assign busBe     = bus_be_q;
   assign busWData  = bus_wdata_q;
   assign lsuRData  = rdata_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sr_lsu.sv
// ---------------------------------------------------------------------------
// tb_sr_lsu
//  Self-checking bench for sr_lsu: a table of directed load/store vectors
//  with hand-computed bus and read-data results, plus hand-written
//  sequences for DONE-ignores-valid, reset mid-transaction and the
//  misaligned word access (behaviour follows SR_LSU_MISALIGN_EN).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sr_lsu;
   import sr_lsu_pkg::*;

   localparam int AW = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          lsuValid = 1'b0;
   logic          dmWe = 1'b0;
   logic          dmSign = 1'b0;
   logic          dmOpByte = 1'b0;
   logic          dmOpHalf = 1'b0;
   logic          dmOpWord = 1'b0;
   logic [AW-1:0] lsuAddr = '0;
   logic [31:0]   lsuWData = '0;
   logic [31:0]   lsuRData;
   logic          lsuStall;
   logic          lsuMisalign;
   logic          busReq;
   logic          busWe;
   logic [AW-1:0] busAddr;
   logic [3:0]    busBe;
   logic [31:0]   busWData;
   logic [31:0]   busRData = '0;
   logic          busAck = 1'b0;
   logic [1:0]    dbg_state;

   sr_lsu #(.AW(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .lsuValid    (lsuValid),
      .dmWe        (dmWe),
      .dmSign      (dmSign),
      .dmOpByte    (dmOpByte),
      .dmOpHalf    (dmOpHalf),
      .dmOpWord    (dmOpWord),
      .lsuAddr     (lsuAddr),
      .lsuWData    (lsuWData),
      .lsuRData    (lsuRData),
      .lsuStall    (lsuStall),
      .lsuMisalign (lsuMisalign),
      .busReq      (busReq),
      .busWe       (busWe),
      .busAddr     (busAddr),
      .busBe       (busBe),
      .busWData    (busWData),
      .busRData    (busRData),
      .busAck      (busAck),
      .dbg_state   (dbg_state)
   );

   // ---------------- scoreboard counters ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Inputs change 1ns after the rising edge; outputs are sampled on the
   // falling edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        we;
      logic        sign;
      logic        op_b;
      logic        op_h;
      logic        op_w;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_wait;
      logic [3:0]  exp_be;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs[NV];

   task automatic drive_access(input vec_t v);
      lsuValid = 1'b1;
      dmWe     = v.we;
      dmSign   = v.sign;
      dmOpByte = v.op_b;
      dmOpHalf = v.op_h;
      dmOpWord = v.op_w;
      lsuAddr  = v.addr;
      lsuWData = v.wdata;
   endtask

   task automatic idle_inputs();
      lsuValid = 1'b0;
      dmWe     = 1'b0;
      dmSign   = 1'b0;
      dmOpByte = 1'b0;
      dmOpHalf = 1'b0;
      dmOpWord = 1'b0;
   endtask

   // Full transaction: IDLE -> REQ (ack_wait extra cycles) -> DONE -> IDLE.
   task automatic run_vec(input vec_t v, input string tag);
      int req_cycles;
      req_cycles = 0;
      drive_access(v);
      @(negedge clk);
      chk({tag, " idle_stall"}, {31'd0, lsuStall}, 32'd1);
      step();
      @(negedge clk);
      chk({tag, " state_req"}, {30'd0, dbg_state}, {30'd0, ST_REQ});
      chk({tag, " busWe"}, {31'd0, busWe}, {31'd0, v.we});
      chk({tag, " busAddr"}, busAddr, v.exp_addr);
      chk({tag, " busBe"}, {28'd0, busBe}, {28'd0, v.exp_be});
      chk({tag, " busWData"}, busWData, v.exp_wdata);
      if (busReq) req_cycles++;
      for (int k = 0; k < v.ack_wait; k++) begin
         step();
         @(negedge clk);
         if (busReq) req_cycles++;
         chk({tag, " wait_stall"}, {31'd0, lsuStall}, 32'd1);
         chk({tag, " wait_addr_stable"}, busAddr, v.exp_addr);
      end
      busAck   = 1'b1;
      busRData = v.rdata;
      step();
      busAck   = 1'b0;
      busRData = 32'h5A5A_5A5A;
      @(negedge clk);
      chk({tag, " req_cycles"}, req_cycles, v.ack_wait + 1);
      chk({tag, " state_done"}, {30'd0, dbg_state}, {30'd0, ST_DONE});
      chk({tag, " done_stall"}, {31'd0, lsuStall}, 32'd0);
      chk({tag, " done_busReq"}, {31'd0, busReq}, 32'd0);
      chk({tag, " lsuRData"}, lsuRData, v.exp_rdata);
      chk({tag, " misalign"}, {31'd0, lsuMisalign}, 32'd0);
      idle_inputs();
      step();
      @(negedge clk);
      chk({tag, " back_idle"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      vec_t v;
      int   episodes;
      logic prev_req;
      logic [2:0] stall_seq;

      //            we sign b  h  w  addr          wdata         rdata         wait be       exp_addr      exp_wdata     exp_rdata
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0103, 32'h1234_5678, 32'h80FF_FF7F, 1, 4'b1000, 32'h0000_0100, 32'h7878_7878, 32'hFFFF_FF80};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0102, 32'h0000_0000, 32'h9234_5678, 0, 4'b1100, 32'h0000_0100, 32'h0000_0000, 32'h0000_9234};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0201, 32'h0000_00AB, 32'hDEAD_BEEF, 4, 4'b0010, 32'h0000_0200, 32'hABAB_ABAB, 32'h0000_0000};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0102, 32'hCAFE_0000, 32'h9234_5678, 2, 4'b1100, 32'h0000_0100, 32'h0000_0000, 32'hFFFF_9234};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0000, 32'hCAFE_F00D, 0, 4'b1111, 32'h0000_0300, 32'h0000_0000, 32'hCAFE_F00D};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0101, 32'h5500_AA11, 32'h1122_33C4, 1, 4'b0010, 32'h0000_0100, 32'h1111_1111, 32'h0000_0033};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0000_00C4, 0, 4'b0001, 32'h0000_0100, 32'h0000_0000, 32'hFFFF_FFC4};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0402, 32'h1234_BEEF, 32'h0000_0000, 3, 4'b1100, 32'h0000_0400, 32'hBEEF_BEEF, 32'h0000_0000};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 32'h0102_0304, 32'hFFFF_FFFF, 0, 4'b1111, 32'h0000_0500, 32'h0102_0304, 32'h0000_0000};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0600, 32'h0000_0000, 32'h8765_4321, 1, 4'b1111, 32'h0000_0600, 32'h0000_0000, 32'h8765_4321};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0604, 32'h0000_AB00, 32'h7FFF_0001, 0, 4'b1111, 32'h0000_0604, 32'h0000_AB00, 32'h7FFF_0001};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0702, 32'h0000_0000, 32'h8000_1234, 0, 4'b1100, 32'h0000_0700, 32'h0000_0000, 32'hFFFF_8000};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0800, 32'h0000_7777, 32'hAAAA_8001, 0, 4'b0011, 32'h0000_0800, 32'h7777_7777, 32'h0000_8001};
      vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_FF03, 32'h1234_56C3, 32'h0000_0000, 2, 4'b1000, 32'h0000_FF00, 32'hC3C3_C3C3, 32'h0000_0000};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0000, 32'h7ABC_0000, 1, 4'b1100, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_7ABC};

      // ---- reset state ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      chk("rst busReq", {31'd0, busReq}, 32'd0);
      chk("rst busWe", {31'd0, busWe}, 32'd0);
      chk("rst busAddr", busAddr, 32'd0);
      chk("rst busBe", {28'd0, busBe}, 32'd0);
      chk("rst busWData", busWData, 32'd0);
      chk("rst lsuRData", lsuRData, 32'd0);
      chk("rst misalign", {31'd0, lsuMisalign}, 32'd0);
      chk("rst stall", {31'd0, lsuStall}, 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // ---- table-driven vectors ----
      for (int i = 0; i < NV; i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i));
      end

      // ---- valid held through DONE, ack in first REQ cycle ----
      v = vecs[4];
      episodes = 0;
      prev_req = 1'b0;
      drive_access(v);
      @(negedge clk);
      stall_seq[2] = lsuStall;
      step();
      @(negedge clk);
      stall_seq[1] = lsuStall;
      if (busReq && !prev_req) episodes++;
      prev_req = busReq;
      busAck   = 1'b1;
      busRData = 32'h0BAD_F00D;
      step();
      busAck = 1'b0;
      @(negedge clk);
      stall_seq[0] = lsuStall;
      chk("hold rdata", lsuRData, 32'h0BAD_F00D);
      // lsuValid still high while in DONE: must not relaunch
      step();
      idle_inputs();
      @(negedge clk);
      chk("hold back_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      for (int k = 0; k < 4; k++) begin
         if (busReq && !prev_req) episodes++;
         prev_req = busReq;
         step();
         @(negedge clk);
      end
      chk("hold stall_seq", {29'd0, stall_seq}, 32'b110);
      chk("hold episodes", episodes, 1);
      chk("hold final_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});

      // ---- reset while busReq is high; ack arrives after release ----
      drive_access(vecs[0]);
      step();
      idle_inputs();
      @(negedge clk);
      chk("rstmid busReq_before", {31'd0, busReq}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid busReq_async", {31'd0, busReq}, 32'd0);
      chk("rstmid state_async", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      step();
      rst_n = 1'b1;
      step();
      busAck   = 1'b1;
      busRData = 32'h1234_5678;
      step();
      busAck = 1'b0;
      @(negedge clk);
      chk("rstmid no_done", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      chk("rstmid busReq", {31'd0, busReq}, 32'd0);
      chk("rstmid lsuRData", lsuRData, 32'd0);
      step();
      @(negedge clk);
      chk("rstmid still_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});

      // Leave a non-zero read value behind so a missing clear shows up below.
      run_vec(vecs[4], "pre_mis");

      // ---- word load at a=0x102 ----
`ifdef SR_LSU_MISALIGN_EN
      v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0102, 32'h0000_0000, 32'h0000_0000, 0, 4'b1111, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000};
      drive_access(v);
      @(negedge clk);
      chk("mis idle_stall", {31'd0, lsuStall}, 32'd1);
      step();
      @(negedge clk);
      chk("mis state_done", {30'd0, dbg_state}, {30'd0, ST_DONE});
      chk("mis busReq", {31'd0, busReq}, 32'd0);
      chk("mis busWe", {31'd0, busWe}, 32'd0);
      chk("mis pulse", {31'd0, lsuMisalign}, 32'd1);
      chk("mis lsuRData", lsuRData, 32'd0);
      chk("mis done_stall", {31'd0, lsuStall}, 32'd0);
      idle_inputs();
      step();
      @(negedge clk);
      chk("mis pulse_end", {31'd0, lsuMisalign}, 32'd0);
      chk("mis back_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      chk("mis no_req", {31'd0, busReq}, 32'd0);
`else
      v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0102, 32'h0000_0000, 32'h1357_2468, 0, 4'b1111, 32'h0000_0100, 32'h0000_0000, 32'h1357_2468};
      run_vec(v, "trunc_lw");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
